// File: rtl/alu_issue_ctrl.sv
// Issue-side ALU controller: decodes one MIPS instruction to an aluc code and
// a/b operands, drives the combinational ALU from registers, and returns a
// write-back packet (result, dest, wen, branch/taken, trap, illegal, flags).
// Ports: clk/rst; in_valid/in_ready + instr/rs_val/rt_val request side;
// alu_a/alu_b/alu_aluc to ALU, alu_r + flags back; out_valid/out_ready + out_*.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_aluc,
  input  logic [31:0] alu_r,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_negative,
  input  logic        alu_overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_wreg,
  output logic        out_wen,
  output logic        out_branch,
  output logic        out_taken,
  output logic        out_trap,
  output logic        out_illegal,
  output logic [3:0]  out_flags
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [3:0] ADDU = 4'h0;
  localparam logic [3:0] SUBU = 4'h1;
  localparam logic [3:0] ADD  = 4'h2;
  localparam logic [3:0] SUB  = 4'h3;
  localparam logic [3:0] AND  = 4'h4;
  localparam logic [3:0] OR   = 4'h5;
  localparam logic [3:0] XOR  = 4'h6;
  localparam logic [3:0] NOR  = 4'h7;
  localparam logic [3:0] LUI  = 4'h8;
  localparam logic [3:0] SLTU = 4'ha;
  localparam logic [3:0] SLT  = 4'hb;
  localparam logic [3:0] SRA  = 4'hc;
  localparam logic [3:0] SRL  = 4'hd;
  localparam logic [3:0] SLL  = 4'he;

  state_t state, state_nx;

  logic [5:0]  op, fn;
  logic [15:0] imm;
  logic [31:0] sx, zx, sh_i, sh_v;
  logic [31:0] d_a, d_b;
  logic [3:0]  d_aluc;
  logic [4:0]  d_wreg;
  logic        d_br, d_bne, d_ill, d_trap_en;

  logic [4:0]  wreg_q;
  logic        br_q, bne_q, ill_q, trap_en_q;
  logic        trap_c;
  logic        unused_rs;

  // rs index is not needed: the register file already supplied rs_val
  assign unused_rs = ^instr[25:21];

  assign op   = instr[31:26];
  assign fn   = instr[5:0];
  assign imm  = instr[15:0];
  assign sx   = {{16{imm[15]}}, imm};
  assign zx   = {16'b0, imm};
  assign sh_i = {27'b0, instr[10:6]};
  assign sh_v = {27'b0, rs_val[4:0]};

  always_comb begin
    d_a    = rs_val;
    d_b    = rt_val;
    d_aluc = ADDU;
    d_wreg = (op == 6'h00) ? instr[15:11] : instr[20:16];
    d_br   = 1'b0;
    d_bne  = 1'b0;
    d_ill  = 1'b0;
    case (op)
      6'h00: begin
        case (fn)
          6'h20: d_aluc = ADD;
          6'h21: d_aluc = ADDU;
          6'h22: d_aluc = SUB;
          6'h23: d_aluc = SUBU;
          6'h24: d_aluc = AND;
          6'h25: d_aluc = OR;
          6'h26: d_aluc = XOR;
          6'h27: d_aluc = NOR;
          6'h2a: d_aluc = SLT;
          6'h2b: d_aluc = SLTU;
          6'h00: begin d_aluc = SLL; d_a = sh_i; end
          6'h02: begin d_aluc = SRL; d_a = sh_i; end
          6'h03: begin d_aluc = SRA; d_a = sh_i; end
          6'h04: begin d_aluc = SLL; d_a = sh_v; end
          6'h06: begin d_aluc = SRL; d_a = sh_v; end
          6'h07: begin d_aluc = SRA; d_a = sh_v; end
          default: d_ill = 1'b1;
        endcase
      end
      6'h04, 6'h05: begin
        d_aluc = SUBU;
        d_br   = 1'b1;
        d_bne  = op[0];
        d_wreg = 5'd0;
      end
      6'h08: begin d_aluc = ADD;  d_b = sx; end
      6'h09: begin d_aluc = ADDU; d_b = sx; end
      6'h0a: begin d_aluc = SLT;  d_b = sx; end
      6'h0b: begin d_aluc = SLTU; d_b = sx; end
      6'h0c: begin d_aluc = AND;  d_b = zx; end
      6'h0d: begin d_aluc = OR;   d_b = zx; end
      6'h0e: begin d_aluc = XOR;  d_b = zx; end
      6'h0f: begin d_aluc = LUI;  d_a = '0; d_b = zx; end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_a    = '0;
      d_b    = '0;
      d_aluc = ADDU;
      d_wreg = 5'd0;
    end
  end

  assign d_trap_en = !d_ill && (d_aluc == ADD || d_aluc == SUB);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = EXEC;
      EXEC:    state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign trap_c    = trap_en_q && (alu_overflow === 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_aluc    <= ADDU;
      wreg_q      <= '0;
      br_q        <= 1'b0;
      bne_q       <= 1'b0;
      ill_q       <= 1'b0;
      trap_en_q   <= 1'b0;
      out_result  <= '0;
      out_wreg    <= '0;
      out_wen     <= 1'b0;
      out_branch  <= 1'b0;
      out_taken   <= 1'b0;
      out_trap    <= 1'b0;
      out_illegal <= 1'b0;
      out_flags   <= '0;
    end else if (state == IDLE && in_valid) begin
      alu_a     <= d_a;
      alu_b     <= d_b;
      alu_aluc  <= d_aluc;
      wreg_q    <= d_wreg;
      br_q      <= d_br;
      bne_q     <= d_bne;
      ill_q     <= d_ill;
      trap_en_q <= d_trap_en;
    end else if (state == EXEC) begin
      out_result  <= ill_q ? 32'd0 : alu_r;
      out_wreg    <= wreg_q;
      out_wen     <= (wreg_q != 5'd0) && !br_q && !ill_q && !trap_c;
      out_branch  <= br_q;
      out_taken   <= br_q && (bne_q ^ (alu_zero === 1'b1));
      out_trap    <= trap_c;
      out_illegal <= ill_q;
      // a floating flag line reads as 0
      out_flags   <= {alu_carry === 1'b1, alu_negative === 1'b1,
                      alu_overflow === 1'b1, alu_zero === 1'b1};
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: behavioural ALU, instruction-level reference
// model, directed test-plan steps and randomized instruction traffic.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_ready, out_valid;
  logic [31:0] instr, rs_val, rt_val, alu_a, alu_b, alu_r, out_result;
  logic [3:0]  alu_aluc, out_flags;
  logic        alu_zero, alu_carry, alu_negative, alu_overflow;
  logic [4:0]  out_wreg;
  logic        out_wen, out_branch, out_taken, out_trap, out_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_r(alu_r),
    .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_negative(alu_negative), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_wreg(out_wreg), .out_wen(out_wen),
    .out_branch(out_branch), .out_taken(out_taken), .out_trap(out_trap),
    .out_illegal(out_illegal), .out_flags(out_flags)
  );

  // behavioural ALU: r = f(a, b), shifts move b by a[4:0]
  logic [32:0] alu_t;
  always_comb begin
    alu_t = '0;
    alu_r = '0;
    alu_carry = 1'b0;
    alu_overflow = 1'b0;
    case (alu_aluc)
      4'h0, 4'h2: begin
        alu_t = {1'b0, alu_a} + {1'b0, alu_b};
        alu_r = alu_t[31:0];
        alu_carry = alu_t[32];
        alu_overflow = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);
      end
      4'h1, 4'h3: begin
        alu_r = alu_a - alu_b;
        alu_carry = alu_a < alu_b;
        alu_overflow = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
      end
      4'h4: alu_r = alu_a & alu_b;
      4'h5: alu_r = alu_a | alu_b;
      4'h6: alu_r = alu_a ^ alu_b;
      4'h7: alu_r = ~(alu_a | alu_b);
      4'h8: alu_r = {alu_b[15:0], 16'b0};
      4'ha: alu_r = {31'b0, alu_a < alu_b};
      4'hb: alu_r = {31'b0, $signed(alu_a) < $signed(alu_b)};
      4'hc: alu_r = $signed(alu_b) >>> alu_a[4:0];
      4'hd: alu_r = alu_b >> alu_a[4:0];
      4'he: alu_r = alu_b << alu_a[4:0];
      default: alu_r = '0;
    endcase
    alu_zero = (alu_r == 32'd0);
    alu_negative = alu_r[31];
  end

  typedef struct packed {
    logic [31:0] a, b;
    logic [3:0]  aluc;
    logic [31:0] res;
    logic [4:0]  wreg;
    logic        wen, br, tk, trap, ill;
    logic [3:0]  flags;
  } exp_t;

  // reference model: MIPS semantics written directly from the instruction
  function automatic exp_t model(input logic [31:0] ins, rs, rt);
    exp_t e;
    logic [5:0] op, fn;
    logic [15:0] im;
    logic [31:0] sx, x, y, r;
    logic [4:0] sh;
    int kind;
    longint s;
    logic c, ov;
    op = ins[31:26]; fn = ins[5:0]; im = ins[15:0];
    sx = {{16{im[15]}}, im}; sh = ins[10:6];
    e = '0; e.a = rs; e.b = rt; kind = 0; x = rs; y = rt; r = 0;
    e.wreg = (op == 0) ? ins[15:11] : ins[20:16];
    case (op)
      6'h00: case (fn)
        6'h20: begin e.aluc = 2; kind = 1; end
        6'h21: begin e.aluc = 0; kind = 1; end
        6'h22: begin e.aluc = 3; kind = 2; end
        6'h23: begin e.aluc = 1; kind = 2; end
        6'h24: begin e.aluc = 4; r = rs & rt; end
        6'h25: begin e.aluc = 5; r = rs | rt; end
        6'h26: begin e.aluc = 6; r = rs ^ rt; end
        6'h27: begin e.aluc = 7; r = ~(rs | rt); end
        6'h2a: begin e.aluc = 11; r = ($signed(rs) < $signed(rt)) ? 1 : 0; end
        6'h2b: begin e.aluc = 10; r = (rs < rt) ? 1 : 0; end
        6'h00: begin e.aluc = 14; e.a = sh; r = rt << sh; end
        6'h02: begin e.aluc = 13; e.a = sh; r = rt >> sh; end
        6'h03: begin e.aluc = 12; e.a = sh; r = $signed(rt) >>> sh; end
        6'h04: begin e.aluc = 14; e.a = rs % 32; r = rt << (rs % 32); end
        6'h06: begin e.aluc = 13; e.a = rs % 32; r = rt >> (rs % 32); end
        6'h07: begin e.aluc = 12; e.a = rs % 32; r = $signed(rt) >>> (rs % 32); end
        default: e.ill = 1;
      endcase
      6'h04, 6'h05: begin
        e.aluc = 1; kind = 2; e.br = 1; e.wreg = 0;
        e.tk = (op == 6'h04) ? (rs == rt) : (rs != rt);
      end
      6'h08: begin e.aluc = 2; e.b = sx; y = sx; kind = 1; end
      6'h09: begin e.aluc = 0; e.b = sx; y = sx; kind = 1; end
      6'h0a: begin e.aluc = 11; e.b = sx; r = ($signed(rs) < $signed(sx)) ? 1 : 0; end
      6'h0b: begin e.aluc = 10; e.b = sx; r = (rs < sx) ? 1 : 0; end
      6'h0c: begin e.aluc = 4; e.b = im; r = rs & im; end
      6'h0d: begin e.aluc = 5; e.b = im; r = rs | im; end
      6'h0e: begin e.aluc = 6; e.b = im; r = rs ^ im; end
      6'h0f: begin e.aluc = 8; e.a = 0; e.b = im; r = im * 65536; end
      default: e.ill = 1;
    endcase
    c = 0; ov = 0;
    if (kind == 1) begin
      r = x + y;
      c = (longint'(x) + longint'(y)) > 64'd4294967295;
      s = longint'($signed(x)) + longint'($signed(y));
      ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end else if (kind == 2) begin
      r = x - y;
      c = x < y;
      s = longint'($signed(x)) - longint'($signed(y));
      ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
    if (e.ill) begin
      e.a = 0; e.b = 0; e.aluc = 0; e.wreg = 0; r = 0; c = 0; ov = 0;
    end
    e.res = r;
    e.trap = ov && (e.aluc == 2 || e.aluc == 3);
    e.wen = (e.wreg != 0) && !e.br && !e.trap && !e.ill;
    e.flags = {c, r[31], ov, r == 0};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // snapshot of the last response, for directed constant checks
  logic [31:0] s_res, s_a, s_b;
  logic [3:0]  s_aluc;
  logic        s_trap, s_wen, s_tk, s_br, s_ill;
  logic [4:0]  s_wreg;

  task automatic chk_out(input string t, input exp_t e);
    chk({t, "_valid"}, out_valid, 1);
    chk({t, "_inrdy"}, in_ready, 0);
    chk({t, "_res"}, out_result, e.res);
    chk({t, "_wreg"}, out_wreg, e.wreg);
    chk({t, "_wen"}, out_wen, e.wen);
    chk({t, "_br"}, out_branch, e.br);
    chk({t, "_tk"}, out_taken, e.tk);
    chk({t, "_trap"}, out_trap, e.trap);
    chk({t, "_ill"}, out_illegal, e.ill);
    chk({t, "_flags"}, out_flags, e.flags);
    chk({t, "_a_hold"}, alu_a, e.a);
  endtask

  task automatic do_op(input logic [31:0] ins, rs, rt, input int hold);
    exp_t e;
    int n;
    e = model(ins, rs, rt);
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("idle_wait", in_ready, 1);
    in_valid = 1; instr = ins; rs_val = rs; rt_val = rt;
    @(posedge clk); #1;
    // junk request while busy must be ignored
    instr = $urandom; rs_val = $urandom; rt_val = $urandom;
    chk("ex_a", alu_a, e.a);
    chk("ex_b", alu_b, e.b);
    chk("ex_aluc", alu_aluc, e.aluc);
    chk("ex_valid", out_valid, 0);
    chk("ex_inrdy", in_ready, 0);
    s_a = alu_a; s_b = alu_b; s_aluc = alu_aluc;
    @(posedge clk); #1;
    chk_out("done", e);
    s_res = out_result; s_trap = out_trap; s_wen = out_wen;
    s_tk = out_taken; s_br = out_branch; s_ill = out_illegal;
    s_wreg = out_wreg;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk_out("hold", e);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0; in_valid = 0;
    chk("rel_valid", out_valid, 0);
    chk("rel_inrdy", in_ready, 1);
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_valid"}, out_valid, 0);
    chk({t, "_inrdy"}, in_ready, 1);
    chk({t, "_a"}, alu_a, 0);
    chk({t, "_b"}, alu_b, 0);
    chk({t, "_aluc"}, alu_aluc, 0);
    chk({t, "_res"}, out_result, 0);
    chk({t, "_flags"}, out_flags, 0);
    chk({t, "_wreg"}, out_wreg, 0);
    chk({t, "_bits"}, {out_wen, out_branch, out_taken, out_trap, out_illegal}, 0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h7fffffff;
      1: return 32'h80000000;
      2: return 32'hffffffff;
      3: return $urandom_range(0, 3);
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [5:0] rf[16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                           6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04,
                           6'h06, 6'h07};
    logic [5:0] io[10] = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c,
                           6'h0d, 6'h0e, 6'h0f};
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: begin w[31:26] = 0; w[5:0] = rf[$urandom_range(0, 15)]; end
      4, 5, 6, 7, 8: w[31:26] = io[$urandom_range(0, 9)];
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) begin
      w[20:16] = 0; w[15:11] = 0;
    end
    return w;
  endfunction

  initial begin
    rst = 1; in_valid = 0; out_ready = 0;
    instr = 0; rs_val = 0; rt_val = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_reset("rst0");

    do_op(32'h00851021, 7, 5, 0);
    chk("addu_aluc", s_aluc, 4'h0);
    chk("addu_res", s_res, 12);
    chk("addu_wreg", s_wreg, 2);
    chk("addu_wen", s_wen, 1);

    do_op(32'h00851020, 32'h7fffffff, 1, 0);
    chk("addov_trap", s_trap, 1);
    chk("addov_wen", s_wen, 0);
    do_op(32'h00851021, 32'h7fffffff, 1, 0);
    chk("adduov_trap", s_trap, 0);
    chk("adduov_res", s_res, 32'h80000000);

    do_op(32'h00051903, 0, 32'hf0000000, 0);
    chk("sra_a", s_a, 4);
    chk("sra_aluc", s_aluc, 4'hc);
    chk("sra_res", s_res, 32'hff000000);
    do_op(32'h00851806, 32'h24, 32'h12345678, 0);
    chk("srlv_a", s_a, 4);
    chk("srlv_aluc", s_aluc, 4'hd);
    do_op(32'h3c071234, 32'hdeadbeef, 0, 0);
    chk("lui_res", s_res, 32'h12340000);

    do_op(32'h10850003, 9, 9, 0);
    chk("beq_br", s_br, 1);
    chk("beq_tk", s_tk, 1);
    chk("beq_wen", s_wen, 0);
    do_op(32'h14850003, 9, 9, 0);
    chk("bne_tk", s_tk, 0);

    do_op(32'h30868000, 32'hffffffff, 0, 0);
    chk("andi_b", s_b, 32'h00008000);
    do_op(32'h20868000, 5, 0, 0);
    chk("addi_b", s_b, 32'hffff8000);
    do_op(32'hfc851021, 3, 4, 0);
    chk("ill_flag", s_ill, 1);
    chk("ill_res", s_res, 0);

    do_op(32'h00851023, 32'h1234, 32'h34, 5);

    // reset while in EXEC discards the pending response
    in_valid = 1; instr = 32'h00851021; rs_val = 1; rt_val = 2;
    @(posedge clk); #1;
    in_valid = 0;
    chk("pre_rst_busy", in_ready, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk_reset("rst_exec");

    for (int k = 0; k < 60; k++)
      do_op(rnd_instr(), rnd_val(), rnd_val(), $urandom_range(0, 3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
